rk8e_dma_bridge: RTL and testbench

Data-break bridge between the RK8E SD-disk engine's DMA master port and the PDP-8 memory bus. It requests the bus from the CPU on behalf of the disk, asserts the disk's `dmaGNT`, and turns each one-cycle disk read or write strobe into a fixed-length memory cycle. It returns read data on `dmaDIN` and flags protocol errors and CPU hold timeouts.

---
 rtl/rk8e_dma_bridge.sv | 212 +++++++++++++++++++++
 tb/tb_rk8e_dma_bridge.sv | 463 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rk8e_dma_bridge.sv
// rk8e_dma_bridge
// Data-break bridge between the RK8E SD-disk DMA master and the PDP-8
// memory bus. Requests the bus from the CPU (cpuHOLD/cpuHLDA), grants it
// to the disk (dmaGNT), and stretches each one-cycle disk read/write
// strobe into a MEM_LAT-cycle memory cycle. Errors are reported through
// sticky flags.
//
// Bit numbering: vectors are declared [N-1:0]. PDP-8 bit 0 (the MSB) is
// bit [N-1] here, so PDP-8 address bits 3..14 are memADDR[11:0].
//
// Ports
//   clk, reset (sync, active-low), clear (IOCLR, sync, active-high)
//   dmaREQ/dmaRD/dmaWR/dmaADDR/dmaDOUT : disk master request side
//   dmaDIN/dmaGNT                      : read data and grant to disk
//   cpuHOLD/cpuHLDA                    : data-break handshake with CPU
//   memADDR/memDOUT/memDIN/memRD/memWR : memory bus
//   wordCNT                            : words moved in current grant
//   dmaOVR/holdTO                      : sticky overrun / hold timeout
module rk8e_dma_bridge #(
  parameter int unsigned MEM_LAT = 3,
  parameter int unsigned HOLD_TO = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        dmaREQ,
  input  logic        dmaRD,
  input  logic        dmaWR,
  input  logic [14:0] dmaADDR,
  input  logic [11:0] dmaDOUT,
  output logic [11:0] dmaDIN,
  output logic        dmaGNT,
  output logic        cpuHOLD,
  input  logic        cpuHLDA,
  output logic [14:0] memADDR,
  output logic [11:0] memDOUT,
  input  logic [11:0] memDIN,
  output logic        memRD,
  output logic        memWR,
  output logic [11:0] wordCNT,
  output logic        dmaOVR,
  output logic        holdTO
);

  localparam int unsigned    TO_W     = $clog2(HOLD_TO + 1);
  localparam logic [3:0]      LAT_LAST = 4'(MEM_LAT - 1);
  localparam logic [TO_W-1:0] TO_LAST  = TO_W'(HOLD_TO - 1);
  localparam logic [TO_W-1:0] TO_MAX   = TO_W'(HOLD_TO);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HOLDREQ,
    S_GRANTED,
    S_MEMCYC,
    S_RELEASE
  } state_t;

  state_t          state_q;
  logic [3:0]      lat_q;
  logic [TO_W-1:0] to_q;
  logic            clr_pend_q;

  logic [11:0] dmaDIN_q;
  logic        dmaGNT_q;
  logic        cpuHOLD_q;
  logic [14:0] memADDR_q;
  logic [11:0] memDOUT_q;
  logic        memRD_q;
  logic        memWR_q;
  logic [11:0] wordCNT_q;
  logic        dmaOVR_q;
  logic        holdTO_q;

  // Outputs are registered alongside the state so each one already
  // reflects the state being entered.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      lat_q      <= '0;
      to_q       <= '0;
      clr_pend_q <= 1'b0;
      dmaDIN_q   <= '0;
      dmaGNT_q   <= 1'b0;
      cpuHOLD_q  <= 1'b0;
      memADDR_q  <= '0;
      memDOUT_q  <= '0;
      memRD_q    <= 1'b0;
      memWR_q    <= 1'b0;
      wordCNT_q  <= '0;
      dmaOVR_q   <= 1'b0;
      holdTO_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (clear) begin
            state_q  <= S_RELEASE;
            dmaOVR_q <= 1'b0;
            holdTO_q <= 1'b0;
            to_q     <= '0;
          end else if (dmaREQ) begin
            state_q   <= S_HOLDREQ;
            cpuHOLD_q <= 1'b1;
            wordCNT_q <= '0;
            to_q      <= '0;
          end
        end

        S_HOLDREQ: begin
          if (clear) begin
            state_q   <= S_RELEASE;
            cpuHOLD_q <= 1'b0;
            dmaOVR_q  <= 1'b0;
            holdTO_q  <= 1'b0;
            to_q      <= '0;
          end else begin
            // Saturating wait counter; the flag only reports, the request
            // keeps waiting for the CPU.
            if (to_q != TO_MAX) to_q <= to_q + 1'b1;
            if (to_q == TO_LAST) holdTO_q <= 1'b1;
            if (cpuHLDA) begin
              state_q  <= S_GRANTED;
              dmaGNT_q <= 1'b1;
            end else if (!dmaREQ) begin
              state_q   <= S_RELEASE;
              cpuHOLD_q <= 1'b0;
            end
          end
        end

        S_GRANTED: begin
          if (clear) begin
            state_q   <= S_RELEASE;
            cpuHOLD_q <= 1'b0;
            dmaGNT_q  <= 1'b0;
            dmaOVR_q  <= 1'b0;
            holdTO_q  <= 1'b0;
            to_q      <= '0;
          end else if (dmaRD && dmaWR) begin
            // Ambiguous access: flag it and drop it.
            dmaOVR_q <= 1'b1;
          end else if (dmaRD || dmaWR) begin
            state_q   <= S_MEMCYC;
            memADDR_q <= dmaADDR;
            if (dmaWR) memDOUT_q <= dmaDOUT;
            memRD_q   <= dmaRD;
            memWR_q   <= dmaWR;
            lat_q     <= '0;
          end else if (!dmaREQ) begin
            state_q   <= S_RELEASE;
            cpuHOLD_q <= 1'b0;
            dmaGNT_q  <= 1'b0;
          end
        end

        S_MEMCYC: begin
          // A strobe here would need a second cycle; it is lost.
          if (dmaRD || dmaWR) dmaOVR_q <= 1'b1;
          // IOCLR is deferred so a write is never cut short.
          if (clear) clr_pend_q <= 1'b1;
          lat_q <= lat_q + 4'd1;
          if (lat_q == LAT_LAST) begin
            memRD_q   <= 1'b0;
            memWR_q   <= 1'b0;
            if (memRD_q) dmaDIN_q <= memDIN;
            wordCNT_q <= wordCNT_q + 12'd1;
            if (clear || clr_pend_q) begin
              state_q    <= S_RELEASE;
              cpuHOLD_q  <= 1'b0;
              dmaGNT_q   <= 1'b0;
              dmaOVR_q   <= 1'b0;
              holdTO_q   <= 1'b0;
              to_q       <= '0;
              clr_pend_q <= 1'b0;
            end else if (dmaREQ) begin
              state_q <= S_GRANTED;
            end else begin
              state_q   <= S_RELEASE;
              cpuHOLD_q <= 1'b0;
              dmaGNT_q  <= 1'b0;
            end
          end
        end

        S_RELEASE: begin
          // One bus-free cycle for the CPU between bursts.
          state_q <= S_IDLE;
          if (clear) begin
            dmaOVR_q <= 1'b0;
            holdTO_q <= 1'b0;
            to_q     <= '0;
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign dmaDIN  = dmaDIN_q;
  assign dmaGNT  = dmaGNT_q;
  assign cpuHOLD = cpuHOLD_q;
  assign memADDR = memADDR_q;
  assign memDOUT = memDOUT_q;
  assign memRD   = memRD_q;
  assign memWR   = memWR_q;
  assign wordCNT = wordCNT_q;
  assign dmaOVR  = dmaOVR_q;
  assign holdTO  = holdTO_q;

endmodule

// File: tb/tb_rk8e_dma_bridge.sv
// Testbench for rk8e_dma_bridge: random addresses/data, memory model that
// returns the low 12 address bits, and a bus monitor that records every
// memory access (direction, address, data, length in cycles).
module tb_rk8e_dma_bridge;

  localparam int MEM_LAT = 3;
  localparam int HOLD_TO = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        clear = 1'b0;
  logic        dmaREQ = 1'b0;
  logic        dmaRD = 1'b0;
  logic        dmaWR = 1'b0;
  logic [14:0] dmaADDR = '0;
  logic [11:0] dmaDOUT = '0;
  logic [11:0] dmaDIN;
  logic        dmaGNT;
  logic        cpuHOLD;
  logic        cpuHLDA = 1'b0;
  logic [14:0] memADDR;
  logic [11:0] memDOUT;
  logic [11:0] memDIN;
  logic        memRD;
  logic        memWR;
  logic [11:0] wordCNT;
  logic        dmaOVR;
  logic        holdTO;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  rk8e_dma_bridge #(.MEM_LAT(MEM_LAT), .HOLD_TO(HOLD_TO)) dut (
    .clk(clk), .reset(reset), .clear(clear),
    .dmaREQ(dmaREQ), .dmaRD(dmaRD), .dmaWR(dmaWR),
    .dmaADDR(dmaADDR), .dmaDOUT(dmaDOUT), .dmaDIN(dmaDIN),
    .dmaGNT(dmaGNT), .cpuHOLD(cpuHOLD), .cpuHLDA(cpuHLDA),
    .memADDR(memADDR), .memDOUT(memDOUT), .memDIN(memDIN),
    .memRD(memRD), .memWR(memWR), .wordCNT(wordCNT),
    .dmaOVR(dmaOVR), .holdTO(holdTO)
  );

  // Memory returns PDP-8 address bits 3..14.
  assign memDIN = memADDR[11:0];

  typedef struct {
    bit          wr;
    logic [14:0] addr;
    logic [11:0] data;
    int          len;
  } acc_t;

  acc_t acc_q[$];
  acc_t cur;
  bit   prev_act = 1'b0;

  always @(negedge clk) begin
    if (memRD === 1'b1 || memWR === 1'b1) begin
      if (!prev_act) begin
        cur.wr   = (memWR === 1'b1);
        cur.addr = memADDR;
        cur.data = memDOUT;
        cur.len  = 0;
      end
      cur.len = cur.len + 1;
      prev_act = 1'b1;
    end else begin
      if (prev_act) acc_q.push_back(cur);
      prev_act = 1'b0;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input bit rd, input bit wr,
                        input logic [14:0] a, input logic [11:0] d);
    dmaRD = rd;
    dmaWR = wr;
    dmaADDR = a;
    dmaDOUT = d;
    tick();
    dmaRD = 1'b0;
    dmaWR = 1'b0;
    dmaADDR = 15'($urandom);
    dmaDOUT = 12'($urandom);
  endtask

  // Raise dmaREQ, answer cpuHOLD with cpuHLDA two cycles later.
  task automatic acquire(output bit ok);
    ok = 1'b0;
    dmaREQ = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (cpuHOLD === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      tick();
      tick();
      cpuHLDA = 1'b1;
      tick();
      cpuHLDA = 1'b0;
      ok = (dmaGNT === 1'b1);
    end
  endtask

  task automatic release_bus();
    dmaREQ = 1'b0;
    repeat (3) tick();
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_reset();
    logic [56:0] outs;
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      clear = 1'($urandom); dmaREQ = 1'($urandom); dmaRD = 1'($urandom);
      dmaWR = 1'($urandom); cpuHLDA = 1'($urandom);
      dmaADDR = 15'($urandom); dmaDOUT = 12'($urandom);
      tick();
    end
    outs = {dmaDIN, dmaGNT, cpuHOLD, memADDR, memDOUT, memRD, memWR,
            wordCNT, dmaOVR, holdTO};
    total++;
    if (outs !== 57'd0) begin
      bad++;
      $display("FAIL reset_outputs: got %h want 0", outs);
    end
    clear = 1'b0; dmaREQ = 1'b0; dmaRD = 1'b0; dmaWR = 1'b0; cpuHLDA = 1'b0;
    reset = 1'b1;
    tick();
    total++;
    if (cpuHOLD !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle: cpuHOLD got %b want 0", cpuHOLD);
    end
    acc_q.delete();
  endtask

  task automatic test_single_write();
    bit ok;
    acc_t a;
    acquire(ok);
    total++;
    if (ok !== 1'b1) begin
      bad++;
      $display("FAIL write_grant: got %b want 1", ok);
    end
    strobe(1'b0, 1'b1, 15'o01234, 12'o5252);
    total++;
    if ({memWR, memRD, memADDR, memDOUT} !== {1'b1, 1'b0, 15'o01234, 12'o5252}) begin
      bad++;
      $display("FAIL write_bus: got wr=%b rd=%b a=%o d=%o want wr=1 rd=0 a=01234 d=5252",
               memWR, memRD, memADDR, memDOUT);
    end
    repeat (3) tick();
    total++;
    if ({memWR, wordCNT} !== {1'b0, 12'd1}) begin
      bad++;
      $display("FAIL write_done: got memWR=%b wordCNT=%o want 0 0001", memWR, wordCNT);
    end
    tick();
    total++;
    if (acc_q.size() != 1) begin
      bad++;
      $display("FAIL write_acc_count: got %0d want 1", acc_q.size());
    end else begin
      a = acc_q.pop_front();
      total++;
      if (a.wr !== 1'b1 || a.addr !== 15'o01234 || a.data !== 12'o5252 || a.len != MEM_LAT) begin
        bad++;
        $display("FAIL write_acc: got wr=%b a=%o d=%o len=%0d want 1 01234 5252 %0d",
                 a.wr, a.addr, a.data, a.len, MEM_LAT);
      end
    end
    total++;
    if (dmaGNT !== 1'b1) begin
      bad++;
      $display("FAIL write_still_granted: got %b want 1", dmaGNT);
    end
    dmaREQ = 1'b0;
    tick();
    tick();
    total++;
    if ({dmaGNT, cpuHOLD} !== 2'b00) begin
      bad++;
      $display("FAIL write_release: got gnt=%b hold=%b want 0 0", dmaGNT, cpuHOLD);
    end
    tick();
    acc_q.delete();
  endtask

  task automatic test_read_burst();
    bit ok;
    logic [14:0] exp_q[$];
    logic [14:0] a;
    acc_t r;
    int acc_bad;
    acquire(ok);
    total++;
    if (ok !== 1'b1) begin
      bad++;
      $display("FAIL burst_grant: got %b want 1", ok);
    end
    for (int i = 0; i < 256; i++) begin
      a = 15'($urandom);
      exp_q.push_back(a);
      strobe(1'b1, 1'b0, a, 12'($urandom));
      repeat (MEM_LAT) tick();
      total++;
      if (dmaDIN !== a[11:0] || wordCNT !== 12'(i + 1)) begin
        bad++;
        $display("FAIL burst_read[%0d]: got din=%o cnt=%o want din=%o cnt=%o",
                 i, dmaDIN, wordCNT, a[11:0], 12'(i + 1));
      end
      repeat (8 - 1 - MEM_LAT) tick();
    end
    total++;
    if (wordCNT !== 12'o0400 || dmaOVR !== 1'b0) begin
      bad++;
      $display("FAIL burst_final: got cnt=%o ovr=%b want 0400 0", wordCNT, dmaOVR);
    end
    total++;
    if (acc_q.size() != 256) begin
      bad++;
      $display("FAIL burst_acc_count: got %0d want 256", acc_q.size());
    end else begin
      acc_bad = 0;
      for (int i = 0; i < 256; i++) begin
        r = acc_q.pop_front();
        if (r.wr !== 1'b0 || r.addr !== exp_q[i] || r.len != MEM_LAT) acc_bad++;
      end
      total++;
      if (acc_bad != 0) begin
        bad++;
        $display("FAIL burst_acc: got %0d bad accesses want 0", acc_bad);
      end
    end
    release_bus();
    acc_q.delete();
  endtask

  task automatic test_overrun();
    bit ok;
    logic [14:0] a1, a2;
    acc_t r;
    a1 = 15'($urandom);
    a2 = a1 ^ 15'o00777;
    acquire(ok);
    total++;
    if (ok !== 1'b1) begin
      bad++;
      $display("FAIL ovr_grant: got %b want 1", ok);
    end
    strobe(1'b1, 1'b0, a1, 12'd0);
    tick();
    strobe(1'b1, 1'b0, a2, 12'd0);
    tick();
    total++;
    if (dmaDIN !== a1[11:0] || dmaOVR !== 1'b1 || wordCNT !== 12'd1) begin
      bad++;
      $display("FAIL ovr_first: got din=%o ovr=%b cnt=%o want din=%o ovr=1 cnt=0001",
               dmaDIN, dmaOVR, wordCNT, a1[11:0]);
    end
    repeat (6) tick();
    total++;
    if (acc_q.size() != 1) begin
      bad++;
      $display("FAIL ovr_acc_count: got %0d want 1", acc_q.size());
    end else begin
      r = acc_q.pop_front();
      total++;
      if (r.addr !== a1 || r.len != MEM_LAT || r.wr !== 1'b0) begin
        bad++;
        $display("FAIL ovr_acc: got a=%o len=%0d want a=%o len=%0d", r.addr, r.len, a1, MEM_LAT);
      end
    end
    release_bus();
    pulse_clear();
    total++;
    if (dmaOVR !== 1'b0) begin
      bad++;
      $display("FAIL ovr_clear_idle: got %b want 0", dmaOVR);
    end
    acc_q.delete();
  endtask

  task automatic test_both_strobes();
    bit ok;
    logic [14:0] a2;
    a2 = 15'($urandom);
    acquire(ok);
    total++;
    if (ok !== 1'b1) begin
      bad++;
      $display("FAIL both_grant: got %b want 1", ok);
    end
    strobe(1'b1, 1'b1, 15'($urandom), 12'($urandom));
    repeat (4) tick();
    total++;
    if (dmaOVR !== 1'b1 || acc_q.size() != 0 || wordCNT !== 12'd0 || dmaGNT !== 1'b1) begin
      bad++;
      $display("FAIL both_ignored: got ovr=%b acc=%0d cnt=%o gnt=%b want 1 0 0000 1",
               dmaOVR, acc_q.size(), wordCNT, dmaGNT);
    end
    strobe(1'b1, 1'b0, a2, 12'd0);
    repeat (MEM_LAT) tick();
    total++;
    if (dmaDIN !== a2[11:0] || wordCNT !== 12'd1) begin
      bad++;
      $display("FAIL both_recover: got din=%o cnt=%o want %o 0001", dmaDIN, wordCNT, a2[11:0]);
    end
    release_bus();
    pulse_clear();
    acc_q.delete();
  endtask

  task automatic test_timeout_clear();
    bit seen;
    logic [14:0] a;
    logic [11:0] d;
    acc_t r;
    a = 15'($urandom);
    d = 12'($urandom);
    seen = 1'b0;
    dmaREQ = 1'b1;
    cpuHLDA = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (cpuHOLD === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    total++;
    if (seen !== 1'b1) begin
      bad++;
      $display("FAIL to_hold: cpuHOLD got %b want 1", cpuHOLD);
    end
    repeat (HOLD_TO - 1) tick();
    total++;
    if (holdTO !== 1'b0) begin
      bad++;
      $display("FAIL to_early: got %b want 0 after %0d cycles", holdTO, HOLD_TO);
    end
    tick();
    total++;
    if (holdTO !== 1'b1 || cpuHOLD !== 1'b1 || dmaGNT !== 1'b0) begin
      bad++;
      $display("FAIL to_set: got to=%b hold=%b gnt=%b want 1 1 0", holdTO, cpuHOLD, dmaGNT);
    end
    cpuHLDA = 1'b1;
    tick();
    cpuHLDA = 1'b0;
    strobe(1'b1, 1'b1, 15'd0, 12'd0);
    total++;
    if (dmaGNT !== 1'b1 || dmaOVR !== 1'b1) begin
      bad++;
      $display("FAIL to_grant_ovr: got gnt=%b ovr=%b want 1 1", dmaGNT, dmaOVR);
    end
    strobe(1'b0, 1'b1, a, d);
    clear = 1'b1;
    dmaREQ = 1'b0;
    tick();
    clear = 1'b0;
    total++;
    if (memWR !== 1'b1 || holdTO !== 1'b1) begin
      bad++;
      $display("FAIL clr_in_cycle: got memWR=%b holdTO=%b want 1 1", memWR, holdTO);
    end
    tick();
    total++;
    if (memWR !== 1'b1) begin
      bad++;
      $display("FAIL clr_no_truncate: got memWR=%b want 1", memWR);
    end
    tick();
    total++;
    if (memWR !== 1'b0 || holdTO !== 1'b0 || dmaOVR !== 1'b0 || wordCNT !== 12'd1) begin
      bad++;
      $display("FAIL clr_done: got wr=%b to=%b ovr=%b cnt=%o want 0 0 0 0001",
               memWR, holdTO, dmaOVR, wordCNT);
    end
    tick();
    total++;
    if (cpuHOLD !== 1'b0 || dmaGNT !== 1'b0) begin
      bad++;
      $display("FAIL clr_release: got hold=%b gnt=%b want 0 0", cpuHOLD, dmaGNT);
    end
    total++;
    if (acc_q.size() != 1) begin
      bad++;
      $display("FAIL clr_acc_count: got %0d want 1", acc_q.size());
    end else begin
      r = acc_q.pop_front();
      total++;
      if (r.wr !== 1'b1 || r.addr !== a || r.data !== d || r.len != MEM_LAT) begin
        bad++;
        $display("FAIL clr_acc: got wr=%b a=%o d=%o len=%0d want 1 %o %o %0d",
                 r.wr, r.addr, r.data, r.len, a, d, MEM_LAT);
      end
    end
    repeat (2) tick();
    acc_q.delete();
  endtask

  task automatic test_reset_midcycle();
    bit ok;
    logic [56:0] outs;
    acquire(ok);
    total++;
    if (ok !== 1'b1) begin
      bad++;
      $display("FAIL rstmid_grant: got %b want 1", ok);
    end
    strobe(1'b0, 1'b1, 15'($urandom), 12'($urandom));
    reset = 1'b0;
    dmaREQ = 1'b0;
    tick();
    outs = {dmaDIN, dmaGNT, cpuHOLD, memADDR, memDOUT, memRD, memWR,
            wordCNT, dmaOVR, holdTO};
    total++;
    if (outs !== 57'd0) begin
      bad++;
      $display("FAIL rstmid_outputs: got %h want 0", outs);
    end
    reset = 1'b1;
    repeat (3) tick();
    acc_q.delete();
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_read_burst();
    test_overrun();
    test_both_strobes();
    test_timeout_clear();
    test_reset_midcycle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
